// File: rtl/ftdi_uart_pkg.sv
// ============================================================================
// Module : ftdi_uart_pkg
// Brief  : Shared FSM state type and width helpers for the FTDI UART.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ftdi_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Counter width that never collapses to zero bits for tiny ranges.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ftdi_uart_if.sv
// ============================================================================
// Module : ftdi_uart_if
// Brief  : Valid/ready byte streams between the bus side and the FTDI UART.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ftdi_uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_overrun
  );
endinterface

`default_nettype wire

// File: rtl/ftdi_fifo.sv
// ============================================================================
// Module : ftdi_fifo
// Brief  : Synchronous FIFO, wrap-bit pointers, head visible combinationally.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ftdi_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int c_PW  = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] wdata,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic      [c_PW:0]    count
);
  typedef logic [c_PW:0] ptr_t;

  logic [WIDTH-1:0] r_mem [DEPTH];
  ptr_t             r_wr;
  ptr_t             r_rd;
  logic             w_push;
  logic             w_pop;

  assign count  = r_wr - r_rd;
  assign full   = (count == ptr_t'(DEPTH));
  assign empty  = (r_wr == r_rd);
  assign rdata  = r_mem[r_rd[c_PW-1:0]];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage is cleared so the head reads zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[c_PW-1:0]] <= wdata;
        r_wr                  <= r_wr + ptr_t'(1);
      end
      if (w_pop) r_rd <= r_rd + ptr_t'(1);
    end
  end
endmodule

`default_nettype wire

// File: rtl/ftdi_uart.sv
// ============================================================================
// Module : ftdi_uart
// Brief  : Full-duplex FTDI UART with RTS#/CTS# flow control and FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ftdi_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int RTS_MARGIN   = 4,
  parameter int FLOW_CTRL    = 1
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  input  wire logic  rxd,
  output logic       txd,
  input  wire logic  cts_n,
  output logic       rts_n,
  ftdi_uart_if.slave bus
);
  import ftdi_uart_pkg::*;

  localparam int c_CNT_W = width_of(CLKS_PER_BIT);
  localparam int c_PW    = $clog2(FIFO_DEPTH);
  typedef logic [c_CNT_W-1:0] cnt_t;
  typedef logic [c_PW:0]      lvl_t;
  localparam cnt_t       c_BIT_END   = cnt_t'(CLKS_PER_BIT - 1);
  localparam cnt_t       c_HALF_END  = cnt_t'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] c_DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] c_STOP_LAST = 3'(STOP_BITS - 1);
  localparam lvl_t       c_MARGIN    = lvl_t'(RTS_MARGIN);

  logic r_rxd_s1, r_rxd_s2, r_cts_s1, r_cts_s2, r_live, r_rts_n;

  logic                 w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic [DATA_BITS-1:0] w_tx_dout;
  lvl_t                 w_tx_level_unused;
  logic                 w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [DATA_BITS-1:0] w_rx_dout;
  lvl_t                 w_rx_level;

  uart_state_t          r_tx_st, r_rx_st;
  cnt_t                 r_tx_cnt, r_rx_cnt;
  logic [2:0]           r_tx_idx, r_rx_idx;
  logic [DATA_BITS-1:0] r_tx_sh, r_rx_sh, w_tx_sh_nxt;
  logic                 r_txd, r_rx_brk, r_ferr, r_ovr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
      r_live   <= 1'b0;
      r_rts_n  <= 1'b1;
    end else begin
      r_rxd_s1 <= rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_cts_s1 <= cts_n;
      r_cts_s2 <= r_cts_s1;
      r_live   <= 1'b1;
      r_rts_n  <= (FLOW_CTRL != 0) ? ((lvl_t'(FIFO_DEPTH) - w_rx_level) < c_MARGIN) : 1'b0;
    end
  end

  assign w_tx_push = bus.tx_valid && bus.tx_ready;
  assign w_tx_pop  = (r_tx_st == IDLE) && !w_tx_empty && ((FLOW_CTRL == 0) || !r_cts_s2);
  assign w_rx_pop  = bus.rx_valid && bus.rx_ready;
  assign w_rx_push = (r_rx_st == STOP) && !r_rx_brk && (r_rx_cnt == c_BIT_END)
                     && r_rxd_s2 && !w_rx_full;
  assign w_tx_sh_nxt = r_tx_sh >> 1;

  ftdi_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_tx_push), .wdata(bus.tx_data), .pop(w_tx_pop),
    .rdata(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_level_unused)
  );

  ftdi_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_rx_push), .wdata(r_rx_sh), .pop(w_rx_pop),
    .rdata(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_level)
  );

  // txd is registered and set on each transition so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_st  <= IDLE;
      r_tx_cnt <= '0;
      r_tx_idx <= '0;
      r_tx_sh  <= '0;
      r_txd    <= 1'b1;
    end else begin
      case (r_tx_st)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_tx_pop) begin
            r_tx_sh  <= w_tx_dout;
            r_tx_cnt <= '0;
            r_tx_st  <= START;
            r_txd    <= 1'b0;
          end
        end
        START: begin
          if (r_tx_cnt == c_BIT_END) begin
            r_tx_cnt <= '0;
            r_tx_idx <= '0;
            r_tx_st  <= DATA;
            r_txd    <= r_tx_sh[0];
          end else r_tx_cnt <= r_tx_cnt + cnt_t'(1);
        end
        DATA: begin
          if (r_tx_cnt == c_BIT_END) begin
            r_tx_cnt <= '0;
            r_tx_sh  <= w_tx_sh_nxt;
            if (r_tx_idx == c_DATA_LAST) begin
              r_tx_idx <= '0;
              r_tx_st  <= STOP;
              r_txd    <= 1'b1;
            end else begin
              r_tx_idx <= r_tx_idx + 3'd1;
              r_txd    <= w_tx_sh_nxt[0];
            end
          end else r_tx_cnt <= r_tx_cnt + cnt_t'(1);
        end
        STOP: begin
          if (r_tx_cnt == c_BIT_END) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == c_STOP_LAST) r_tx_st  <= IDLE;
            else                         r_tx_idx <= r_tx_idx + 3'd1;
          end else r_tx_cnt <= r_tx_cnt + cnt_t'(1);
        end
        default: r_tx_st <= IDLE;
      endcase
    end
  end

  // r_rx_brk holds the FSM in STOP after a framing error until the line idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_st  <= IDLE;
      r_rx_cnt <= '0;
      r_rx_idx <= '0;
      r_rx_sh  <= '0;
      r_rx_brk <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
      case (r_rx_st)
        IDLE: begin
          r_rx_cnt <= '0;
          if (!r_rxd_s2) r_rx_st <= START;
        end
        START: begin
          if (r_rx_cnt == c_HALF_END) begin
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
            r_rx_st  <= r_rxd_s2 ? IDLE : DATA;
          end else r_rx_cnt <= r_rx_cnt + cnt_t'(1);
        end
        DATA: begin
          if (r_rx_cnt == c_BIT_END) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {r_rxd_s2, r_rx_sh[DATA_BITS-1:1]};
            if (r_rx_idx == c_DATA_LAST) r_rx_st  <= STOP;
            else                         r_rx_idx <= r_rx_idx + 3'd1;
          end else r_rx_cnt <= r_rx_cnt + cnt_t'(1);
        end
        STOP: begin
          if (r_rx_brk) begin
            if (r_rxd_s2) begin
              r_rx_brk <= 1'b0;
              r_rx_st  <= IDLE;
            end
          end else if (r_rx_cnt == c_BIT_END) begin
            r_rx_cnt <= '0;
            if (r_rxd_s2) begin
              r_ovr   <= w_rx_full;
              r_rx_st <= IDLE;
            end else begin
              r_ferr   <= 1'b1;
              r_rx_brk <= 1'b1;
            end
          end else r_rx_cnt <= r_rx_cnt + cnt_t'(1);
        end
        default: r_rx_st <= IDLE;
      endcase
    end
  end

  assign txd              = r_txd;
  assign rts_n            = r_rts_n;
  assign bus.tx_ready     = r_live && !w_tx_full;
  assign bus.rx_valid     = !w_rx_empty;
  assign bus.rx_data      = w_rx_dout;
  assign bus.rx_frame_err = r_ferr;
  assign bus.rx_overrun   = r_ovr;
endmodule

`default_nettype wire

// File: tb/tb_ftdi_uart.sv
// ============================================================================
// Module : tb_ftdi_uart
// Brief  : Self-checking bench: random bytes against a queue/frame-rule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ftdi_uart;
  localparam int CPB    = 4;
  localparam int DB     = 8;
  localparam int DEPTH  = 16;
  localparam int MARGIN = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic cts_n = 1'b1;
  logic txd;
  logic rts_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_ferr  = 0;
  int n_ovr   = 0;
  logic [7:0] rx_q [$];

  ftdi_uart_if #(.DATA_BITS(DB)) bus ();

  ftdi_uart #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(1),
    .FIFO_DEPTH(DEPTH), .RTS_MARGIN(MARGIN), .FLOW_CTRL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .txd(txd),
    .cts_n(cts_n), .rts_n(rts_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.rx_frame_err === 1'b1) n_ferr++;
    if (bus.rx_overrun === 1'b1)   n_ovr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_tx(input logic [7:0] b);
    check("tx_ready_before_push", bus.tx_ready, 1'b1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  // Expected line level: start 0, data LSB first, stop 1.
  task automatic tx_expect(input logic [7:0] b, input bit raise_cts, output int t_start);
    int t = 0;
    logic exp_bit;
    while (txd !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("tx_start_seen", (txd === 1'b0), 1'b1);
    t_start = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) repeat (CPB) @(negedge clk);
      if (raise_cts && k == 3) cts_n = 1'b1;
      exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      check("txd_bit", txd, exp_bit);
    end
  endtask

  task automatic count_tx_low(input int ncyc, output int lows);
    lows = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
  endtask

  // stop_low > 0 holds the line low that many cycles in place of the stop bit.
  task automatic send_rx(input logic [7:0] b, input int stop_low);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (CPB) @(negedge clk);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      repeat (stop_low) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (CPB + 4) @(negedge clk);
  endtask

  task automatic rx_frame_model(input logic [7:0] b);
    int f0 = n_ferr;
    int o0 = n_ovr;
    bit exp_ovr = (rx_q.size() == DEPTH);
    send_rx(b, 0);
    if (!exp_ovr) rx_q.push_back(b);
    check("rx_overrun_pulses", n_ovr - o0, exp_ovr);
    check("rx_ferr_pulses", n_ferr - f0, 0);
    check("rts_n_level", rts_n, (DEPTH - rx_q.size()) < MARGIN);
    check("rx_valid", bus.rx_valid, rx_q.size() > 0);
    if (rx_q.size() > 0) check("rx_head", bus.rx_data, rx_q[0]);
  endtask

  task automatic pop_rx();
    check("pop_rx_valid", bus.rx_valid, 1'b1);
    check("pop_rx_data", bus.rx_data, rx_q[0]);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    void'(rx_q.pop_front());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, lows, f0;
    logic [7:0] b0, b1, b2;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_rts_n", rts_n, 1'b1);
    check("rst_tx_ready", bus.tx_ready, 1'b0);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx_ready", bus.tx_ready, 1'b1);
    check("post_rst_rts_n", rts_n, 1'b0);

    // TX framing and one-cycle inter-frame gap
    cts_n = 1'b0;
    repeat (3) @(negedge clk);
    b1 = 8'($urandom);
    push_tx(8'hA5);
    push_tx(b1);
    tx_expect(8'hA5, 1'b0, t0);
    tx_expect(b1, 1'b0, t1);
    check("tx_start_to_start", t1 - t0, CPB * 10 + 1);
    repeat (CPB + 4) @(negedge clk);

    // CTS# gating
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    push_tx(b0); push_tx(b1); push_tx(b2);
    count_tx_low(60, lows);
    check("cts_hold_txd_low_cycles", lows, 0);
    check("cts_hold_tx_ready", bus.tx_ready, 1'b1);
    cts_n = 1'b0;
    tx_expect(b0, 1'b0, t0);
    tx_expect(b1, 1'b1, t1);
    count_tx_low(80, lows);
    check("cts_withheld_txd_low_cycles", lows, 0);
    cts_n = 1'b0;
    tx_expect(b2, 1'b0, t0);
    repeat (CPB + 4) @(negedge clk);

    // RX single frame, then glitch
    rx_frame_model(8'h3C);
    pop_rx();
    f0 = n_ferr;
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_rx_valid", bus.rx_valid, 1'b0);
    check("glitch_ferr", n_ferr - f0, 0);

    // Framing error followed by a long break
    f0 = n_ferr;
    send_rx(8'($urandom), CPB + 40);
    check("break_ferr_once", n_ferr - f0, 1);
    check("break_rx_valid", bus.rx_valid, 1'b0);

    // Flood with consumer stalled: RTS# and overrun behaviour
    for (int i = 0; i < 18; i++) rx_frame_model(8'($urandom));
    for (int i = 0; i < DEPTH; i++) begin
      pop_rx();
      @(negedge clk);
      check("drain_rts_n", rts_n, (DEPTH - rx_q.size()) < MARGIN);
    end
    check("drain_rx_valid", bus.rx_valid, 1'b0);

    // Reset in the middle of TX and RX frames
    rx_frame_model(8'($urandom));
    push_tx(8'($urandom));
    t0 = 0;
    while (txd !== 1'b0 && t0 < 100) begin
      @(negedge clk);
      t0++;
    end
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_rts_n", rts_n, 1'b1);
    check("midrst_rx_valid", bus.rx_valid, 1'b0);
    check("midrst_tx_ready", bus.tx_ready, 1'b0);
    rx_q.delete();
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerst_tx_ready", bus.tx_ready, 1'b1);
    check("rerst_rts_n", rts_n, 1'b0);
    count_tx_low(50, lows);
    check("rerst_tx_fifo_lost", lows, 0);
    rx_frame_model(8'($urandom));
    pop_rx();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ftdi_uart.md
Name: ftdi_uart

Overview:
- Parametrised UART controller for the FTDI serial link: full-duplex TX/RX with RTS#/CTS# hardware flow control and a buffering FIFO per direction.
- Drives the FTDI pins directly: RXD in, TXD out, CTS# in, RTS# out.
- Presents valid/ready byte streams to the CPU/bus side.
- Generalises the bare pin bundle with configurable bit timing, frame format, FIFO depth and flow-control mode.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); must be >= 4.
- DATA_BITS, 8, data bits per frame, range 5..8; sent and received LSB first.
- STOP_BITS, 1, stop bits transmitted, 1 or 2; RX checks the first stop bit only.
- FIFO_DEPTH, 16, entries per FIFO; power of two, >= 4.
- RTS_MARGIN, 4, RTS# deasserts when RX FIFO free entries < RTS_MARGIN.
- FLOW_CTRL, 1, 1 = honour CTS# and drive RTS#; 0 = ignore CTS#, RTS# held low.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rxd  in  1  FTDI BD0, serial data from host
- txd  out  1  FTDI BD1, serial data to host
- cts_n  in  1  FTDI BD2, host ready to receive (low = ready)
- rts_n  out  1  FTDI BD3, block ready to receive (low = ready)
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX FIFO can accept
- rx_data  out  DATA_BITS  received byte (FIFO head)
- rx_valid  out  1  RX FIFO non-empty
- rx_ready  in  1  consumer pops rx_data
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled low, byte dropped
- rx_overrun  out  1  one-cycle pulse: byte received with RX FIFO full, byte dropped

Behaviour:
- Reset (async assert, sync release):
  - txd=1, rts_n=1, tx_ready=0, rx_valid=0, rx_data=0, pulses=0, both FIFOs empty, both FSMs IDLE.
  - tx_ready=1 and rts_n=0 (if FLOW_CTRL) from the first clock edge after release.
- Input synchronisation: rxd and cts_n pass through 2-flop synchronisers; all decisions use the synchronised values. rxd synchroniser resets to 1, cts_n to 1.
- FIFO handshakes:
  - Push on valid&&ready; pop on valid&&ready.
  - tx_ready = !tx_full. rx_valid = !rx_empty; rx_data shows the head combinationally from FIFO storage.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leaves the count unchanged.
- TX FSM states: IDLE, START, DATA, STOP. Bit counter 0..CLKS_PER_BIT-1.
  - IDLE -> START when TX FIFO non-empty and (FLOW_CTRL==0 or cts_n_sync==0). Pop the byte into a shift register on that cycle.
  - START drives txd=0 for CLKS_PER_BIT cycles.
  - DATA sends DATA_BITS bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP drives txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then returns to IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle between frames.
  - CTS# rising mid-frame does not abort; the current frame completes and the next start is withheld.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on rxd_sync==0.
  - START waits CLKS_PER_BIT/2 cycles, then re-samples. If rxd_sync==1 it is a false start: return to IDLE with no event.
  - DATA samples every CLKS_PER_BIT cycles at mid-bit, shifting in LSB first.
  - STOP samples at mid-bit:
    - sample 1 and FIFO not full: push the byte.
    - sample 1 and FIFO full: pulse rx_overrun, discard the byte.
    - sample 0: pulse rx_frame_err, discard the byte, and wait for rxd_sync==1 before returning to IDLE (break condition does not retrigger).
  - After the stop sample the FSM returns to IDLE immediately, so the next start edge can be caught within the stop bit's second half.
- RTS#: registered; rts_n = (free entries < RTS_MARGIN) when FLOW_CTRL=1, else 0. Updates one cycle after a count change.
- Reset mid-frame: txd returns to 1 immediately (async); partial RX byte discarded; FIFO contents lost.

Decomposition:
- Package ftdi_uart_pkg:
  - enum uart_state_t {IDLE, START, DATA, STOP}, shared by TX and RX FSMs.
  - Localparam helpers: bit-counter width clog2(CLKS_PER_BIT), FIFO pointer width clog2(FIFO_DEPTH).
- Sub-module ftdi_fifo: WIDTH and DEPTH parameters; push/pop, full, empty, count; pointers with an extra wrap bit. Instantiated twice.
- TX and RX FSMs live in ftdi_uart.

Test Plan:
- TX with CLKS_PER_BIT=4, cts_n=0; push 0xA5 -> txd sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 4 cycles; next push sent with 1 idle cycle between frames.
- cts_n=1 with 3 bytes pushed -> txd stays 1 and tx_ready stays 1. Drop cts_n -> all 3 sent in order. Raise cts_n mid-second-frame -> second frame completes, third withheld.
- RX frame 0x3C at 4 clk/bit -> rx_valid rises with rx_data=0x3C. A 1-cycle low glitch on rxd -> no byte, no error.
- RX frame with stop bit 0 -> rx_frame_err pulses once, rx_valid stays 0. rxd held low 40 cycles then released -> still only one error.
- FIFO_DEPTH=16, RTS_MARGIN=4, rx_ready=0; send 18 bytes:
  - rts_n rises one cycle after the 13th byte is pushed.
  - Bytes 17 and 18 each pulse rx_overrun.
  - Popping 16 bytes returns bytes 1..16 in order.
  - rts_n falls once free entries >= 4.
- Assert rst_n low mid-TX-frame and mid-RX-frame -> txd=1, rts_n=1, rx_valid=0 immediately. After release, a clean frame is received correctly.
